edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter.sv | 132 +++++++++++++
 tb/tb_edge_event_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge detector with round-robin event arbiter and registered output stage
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   sig_in,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [2*N_CH-1:0] edge_mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_ch,
  output logic              evt_rise,
  output logic [N_CH-1:0]   ovf,
  input  logic [N_CH-1:0]   ovf_clr
);

  logic [N_CH-1:0] sig_prev_q;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] det;

  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] kind_q, kind_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] clr_sel;

  logic            evt_valid_q;
  logic [ID_W-1:0] evt_ch_q;
  logic            evt_rise_q;
  logic [ID_W-1:0] last_grant_q;

  logic            found;
  logic [ID_W-1:0] grant;
  logic            load;

  // Previous-level register; it tracks sig_in even in reset so no edge appears right after release
  always_ff @(posedge clk) begin
    sig_prev_q <= sig_in;
  end

  // Edge qualification against the per-channel mode and enable
  always_comb begin
    rise = sig_in & ~sig_prev_q;
    fall = ~sig_in & sig_prev_q;
    det  = '0;
    for (int i = 0; i < N_CH; i++) begin
      det[i] = ch_en[i] & ((rise[i] & edge_mode[2*i]) | (fall[i] & edge_mode[2*i+1]));
    end
  end

  // Round-robin pick: first pending channel above the last grant, wrapping at N_CH
  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    sel   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_grant_q) + k) % N_CH;
      sel = idx[ID_W-1:0];
      if (!found && pend_q[sel]) begin
        found = 1'b1;
        grant = sel;
      end
    end
  end

  // The output stage takes a new event whenever it is empty or being drained this cycle
  assign load = (!evt_valid_q || evt_ready) && found;

  // Pending/kind/overflow next state; a channel being loaded frees its slot for a same-cycle edge
  always_comb begin
    pend_d  = pend_q;
    kind_d  = kind_q;
    ovf_d   = ovf_q & ~ovf_clr;
    clr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      clr_sel[i] = load && (int'(grant) == i);
      if (!ch_en[i]) begin
        pend_d[i] = 1'b0;
      end else if (det[i]) begin
        if (!pend_q[i] || clr_sel[i]) begin
          pend_d[i] = 1'b1;
          kind_d[i] = rise[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end else if (clr_sel[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      kind_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      kind_q <= kind_d;
      ovf_q  <= ovf_d;
    end
  end

  // Registered output stage; holds its contents while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid_q  <= 1'b0;
      evt_ch_q     <= '0;
      evt_rise_q   <= 1'b0;
      last_grant_q <= ID_W'(N_CH - 1);
    end else if (load) begin
      evt_valid_q  <= 1'b1;
      evt_ch_q     <= grant;
      evt_rise_q   <= kind_q[grant];
      last_grant_q <= grant;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_q  <= 1'b0;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [3:0] ch_en;
  logic [7:0] edge_mode;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;

  int n_pass;
  int n_chk;

  edge_event_arbiter #(.N_CH(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .ch_en     (ch_en),
    .edge_mode (edge_mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] s);
    rst_n     = 1'b0;
    sig_in    = s;
    ch_en     = 4'hF;
    edge_mode = 8'h55;
    evt_ready = 1'b1;
    ovf_clr   = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;

    // reset state
    do_reset(4'h0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ch", evt_ch, 0);
    chk("rst_rise", evt_rise, 0);
    chk("rst_ovf", ovf, 0);

    // simultaneous rises on ch0, ch1, ch3 drain in index order from reset grant pointer
    sig_in = 4'b1011;
    tick();
    chk("multi_pend_valid", evt_valid, 0);
    tick();
    chk("multi_v0", evt_valid, 1);
    chk("multi_ch0", evt_ch, 0);
    tick();
    chk("multi_ch1", evt_ch, 1);
    tick();
    chk("multi_ch3", evt_ch, 3);
    chk("multi_rise3", evt_rise, 1);
    tick();
    chk("multi_drain", evt_valid, 0);

    // single rise: latency of two cycles, one-cycle valid pulse
    do_reset(4'h0);
    sig_in = 4'b0100;
    tick();
    chk("lat_t1_valid", evt_valid, 0);
    tick();
    chk("lat_t2_valid", evt_valid, 1);
    chk("lat_ch", evt_ch, 2);
    chk("lat_rise", evt_rise, 1);
    tick();
    chk("lat_drop", evt_valid, 0);

    // stalled consumer, ch1 both edges: hold, pend fall, overflow on next rise, clear
    do_reset(4'h0);
    edge_mode = 8'h5D;
    evt_ready = 1'b0;
    sig_in    = 4'b0010;
    tick();
    chk("ovf_pend_valid", evt_valid, 0);
    tick();
    chk("ovf_held_valid", evt_valid, 1);
    chk("ovf_held_ch", evt_ch, 1);
    sig_in = 4'b0000;
    tick();
    chk("ovf_hold_rise", evt_rise, 1);
    chk("ovf_none_yet", ovf, 0);
    sig_in = 4'b0010;
    tick();
    chk("ovf_set", ovf, 4'b0010);
    chk("ovf_stable_ch", evt_ch, 1);
    chk("ovf_stable_rise", evt_rise, 1);
    ovf_clr = 4'b0010;
    tick();
    chk("ovf_clr", ovf, 0);
    ovf_clr   = 4'b0000;
    evt_ready = 1'b1;
    tick();
    chk("ovf_next_valid", evt_valid, 1);
    chk("ovf_kind_kept", evt_rise, 0);
    tick();
    chk("ovf_empty", evt_valid, 0);

    // ch0 and ch1 toggling every cycle: grants alternate
    do_reset(4'h0);
    edge_mode = 8'h5F;
    sig_in    = 4'b0011;
    tick();
    for (int i = 0; i < 4; i++) begin
      sig_in = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      tick();
      chk("rr_valid", evt_valid, 1);
      chk("rr_ch", evt_ch, i % 2);
    end

    // inputs high through reset produce no event
    do_reset(4'hF);
    tick();
    chk("hi_rel_0", evt_valid, 0);
    tick();
    chk("hi_rel_1", evt_valid, 0);

    // reset mid-handshake discards presented and pending events
    edge_mode = 8'hAA;
    evt_ready = 1'b0;
    sig_in    = 4'h0;
    tick();
    tick();
    chk("mid_valid", evt_valid, 1);
    chk("mid_ch", evt_ch, 0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", evt_valid, 0);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    tick();
    chk("mid_pend_gone0", evt_valid, 0);
    tick();
    chk("mid_pend_gone1", evt_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
